pipe_ex_md: RTL and testbench
=============================

# pipe_ex_md

Parametrised execute stage with an integrated EX/MEM pipeline register and an iterative multiply/divide unit owning the HI/LO registers. It sits between the ID/EX register and the memory stage. It forwards memory and writeback control, computes the ALU result from the selected operands, and runs MULT/MULTU/DIV/DIVU in the background. It stalls the upstream pipeline only when a later instruction needs HI/LO or the multiply/divide unit while that unit is still busy.

## Interface
Parameters:
- WIDTH, 32: datapath width; the multiply/divide latency equals WIDTH cycles.

Ports:
- in_clk  input  1  clock; all state updates on the rising edge.
- in_rst_n  input  1  reset, asynchronous and active-low.
- in_valid  input  1  the EX input holds a real instruction.
- in_flush  input  1  kill the instruction currently at the EX input.
- in_dmem_ena, in_dmem_wena  input  1 each  memory control, passed through.
- in_dmem_type  input  2  memory access type, passed through.
- in_rs_data, in_rt_data  input  WIDTH each  register operands.
- in_immed, in_shamt  input  WIDTH each  extended immediate and shift amount.
- in_rd_waddr  input  5  destination register address.
- in_rd_sel, in_rd_wena  input  1 each  writeback control.
- in_alu_a_sel  input  1  A operand select: 1 = shamt, 0 = rs.
- in_alu_b_sel  input  1  B operand select: 1 = immed, 0 = rt.
- in_alu_sel  input  4  ALU operation; uses the same aluc encoding as the team alu.
- in_md_op  input  3  multiply/divide operation:
  - 0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as none).
- in_hilo_rd  input  2  HI/LO read: 0 none, 1 MFHI, 2 MFLO, 3 reserved (treated as none).
- out_stall  output  1  the upstream stages must hold; the EX input is not consumed.
- out_valid  output  1  the EX/MEM register holds a real instruction.
- out_dmem_ena, out_dmem_wena, out_dmem_type, out_rs_data, out_rt_data, out_rd_waddr, out_rd_sel, out_rd_wena  output  as inputs  registered copies of the matching inputs.
- out_alu_result  output  WIDTH  registered result: ALU result, or HI/LO for MFHI/MFLO.
- out_overflow  output  1  registered signed-add/sub overflow flag from the ALU.
- out_md_busy  output  1  the multiply/divide unit is iterating.

## Operation
- Operand A = in_alu_a_sel ? in_shamt : in_rs_data.
- Operand B = in_alu_b_sel ? in_immed : in_rt_data.
- The ALU is combinational, WIDTH wide.
- Accept condition: accept = in_valid & ~out_stall & ~in_flush.
- Stall condition: out_stall = in_valid & ~in_flush & out_md_busy & (in_md_op in 1..6 | in_hilo_rd in 1..2).
- EX/MEM register, at each edge:
  - out_valid <= accept.
  - When out_valid <= 1, every data and control output loads from the inputs.
  - When out_valid <= 0, the data outputs hold their value; out_rd_wena and out_dmem_ena are forced to 0 (bubble).
- MFHI/MFLO: out_alu_result <= HI or LO; the ALU result is discarded.
- MTHI/MTLO, on accept: HI or LO <= in_rs_data at that edge; the other register is unchanged.
- MULT/MULTU/DIV/DIVU, on accept:
  - Latch both operands from rs and rt (ignoring the operand selects), latch the op, load the counter with WIDTH, and set busy.
  - The instruction itself proceeds through the EX/MEM register; the unit does not stall it.
- Iteration: shift-add multiply or restoring divide, one bit per cycle.
  - Signed ops convert operands to magnitudes first and fix the sign at completion.
- Arithmetic rules:
  - MULT/MULTU: {HI,LO} = 2*WIDTH-bit product; signed for MULT, unsigned for MULTU.
  - DIV/DIVU: LO = quotient, HI = remainder.
    - The quotient truncates toward zero.
    - The remainder takes the sign of the dividend.
  - Divide by zero: LO = all ones, HI = dividend.
  - Signed divide of minimum value by -1: LO = minimum value, HI = 0.
- Flush:
  - Kills the EX input instruction: no EX/MEM capture, no multiply/divide start, no HI/LO write.
  - An operation already iterating continues and completes.

## Timing
- Reset (in_rst_n low, asynchronous): every output is 0; HI = LO = 0; busy = 0; counter = 0.
- Reset mid-operation aborts the multiply/divide with no HI/LO write.
- Plain ALU ops have 1-cycle latency: inputs valid before edge k appear on the outputs after edge k.
- Multiply/divide issued at edge k:
  - out_md_busy is high from after edge k through edge k+WIDTH.
  - HI/LO are written at edge k+WIDTH, and busy falls at that same edge.
- An MFHI/MFLO or another multiply/divide op presented while busy stalls until busy drops.
  - It is accepted at the first edge with busy low and reads the new HI/LO.
  - Back-to-back example: issue at edge k, dependent MFLO presented in cycle k+1, stall for cycles k+1..k+WIDTH, MFLO accepted at edge k+WIDTH+1 with the final LO.
- Stall and flush asserted together: flush wins; out_stall = 0 and a bubble is inserted.
- There is no back-pressure from MEM; this stage never holds its own output register.

## Test plan
- Reset: in_rst_n low mid-run -> all outputs 0 immediately (asynchronous); HI/LO read back 0 after release.
- ALU: rs=5, rt=7, alu_b_sel=0, ADD code -> out_alu_result=12 one edge later.
  - Back-to-back ops produce one result per cycle with out_stall=0.
- MULT, WIDTH=32: rs=0xFFFFFFFD (-3), rt=4.
  - MFLO the following cycle -> out_stall held for 32 cycles, then LO=0xFFFFFFF4.
  - MFHI afterwards -> 0xFFFFFFFF.
- DIV: rs=-7, rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIVU 9/0 -> LO=0xFFFFFFFF, HI=9.
  - DIV 0x80000000/-1 -> LO=0x80000000, HI=0.
- Non-blocking: MULTU 3*5, then ten independent ADDs with no stall; MFLO after busy drops -> 15, no stall.
- Flush: MTHI rs=0xAA with in_flush=1 -> HI unchanged and out_valid=0.
  - Flush during a stalled MFLO -> out_stall drops, bubble inserted, multiply still completes.

Source files
------------

// File: rtl/pipe_ex_md.sv
// pipe_ex_md: execute stage with the EX/MEM pipeline register and an
// iterative multiply/divide unit that owns HI/LO. The unit runs in the
// background; only instructions that touch HI/LO or the unit wait for it.
module pipe_ex_md #(
    parameter int WIDTH = 32
) (
    input  logic             in_clk,
    input  logic             in_rst_n,
    input  logic             in_valid,
    input  logic             in_flush,
    input  logic             in_dmem_ena,
    input  logic             in_dmem_wena,
    input  logic [1:0]       in_dmem_type,
    input  logic [WIDTH-1:0] in_rs_data,
    input  logic [WIDTH-1:0] in_rt_data,
    input  logic [WIDTH-1:0] in_immed,
    input  logic [WIDTH-1:0] in_shamt,
    input  logic [4:0]       in_rd_waddr,
    input  logic             in_rd_sel,
    input  logic             in_rd_wena,
    input  logic             in_alu_a_sel,
    input  logic             in_alu_b_sel,
    input  logic [3:0]       in_alu_sel,
    input  logic [2:0]       in_md_op,
    input  logic [1:0]       in_hilo_rd,
    output logic             out_stall,
    output logic             out_valid,
    output logic             out_dmem_ena,
    output logic             out_dmem_wena,
    output logic [1:0]       out_dmem_type,
    output logic [WIDTH-1:0] out_rs_data,
    output logic [WIDTH-1:0] out_rt_data,
    output logic [4:0]       out_rd_waddr,
    output logic             out_rd_sel,
    output logic             out_rd_wena,
    output logic [WIDTH-1:0] out_alu_result,
    output logic             out_overflow,
    output logic             out_md_busy
);

    localparam int CW  = $clog2(WIDTH + 1);
    localparam int SHW = $clog2(WIDTH);

    localparam logic [2:0] MD_MULT  = 3'd1;
    localparam logic [2:0] MD_MULTU = 3'd2;
    localparam logic [2:0] MD_DIV   = 3'd3;
    localparam logic [2:0] MD_DIVU  = 3'd4;
    localparam logic [2:0] MD_MTHI  = 3'd5;
    localparam logic [2:0] MD_MTLO  = 3'd6;

    // Two's-complement negate of a single-width value when neg is set
    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] x, input logic neg);
        return neg ? (~x + 1'b1) : x;
    endfunction

    // Two's-complement negate of a double-width product when neg is set
    function automatic logic [2*WIDTH-1:0] cond_neg2(input logic [2*WIDTH-1:0] x, input logic neg);
        return neg ? (~x + 1'b1) : x;
    endfunction

    // ---- stage p0: operand select, ALU, issue control ----
    logic signed [WIDTH-1:0] alu_a_p0, alu_b_p0;
    logic        [WIDTH-1:0] alu_res_p0;
    logic                    alu_ovf_p0;
    logic        [WIDTH-1:0] sum_p0, dif_p0;

    logic                    md_busy;
    logic [CW-1:0]           md_cnt;
    logic [WIDTH-1:0]        hi_q, lo_q;

    logic accept, needs_md, md_start, mt_hi, mt_lo;

    assign alu_a_p0 = in_alu_a_sel ? in_shamt : in_rs_data;
    assign alu_b_p0 = in_alu_b_sel ? in_immed : in_rt_data;
    assign sum_p0   = alu_a_p0 + alu_b_p0;
    assign dif_p0   = alu_a_p0 - alu_b_p0;

    // Combinational ALU using the aluc encoding shared with the team alu
    always_comb begin
        alu_res_p0 = '0;
        alu_ovf_p0 = 1'b0;
        case (in_alu_sel)
            4'b0000: alu_res_p0 = sum_p0;
            4'b0010: begin
                alu_res_p0 = sum_p0;
                alu_ovf_p0 = (alu_a_p0[WIDTH-1] == alu_b_p0[WIDTH-1]) &&
                             (sum_p0[WIDTH-1] != alu_a_p0[WIDTH-1]);
            end
            4'b0001: alu_res_p0 = dif_p0;
            4'b0011: begin
                alu_res_p0 = dif_p0;
                alu_ovf_p0 = (alu_a_p0[WIDTH-1] != alu_b_p0[WIDTH-1]) &&
                             (dif_p0[WIDTH-1] != alu_a_p0[WIDTH-1]);
            end
            4'b0100: alu_res_p0 = alu_a_p0 & alu_b_p0;
            4'b0101: alu_res_p0 = alu_a_p0 | alu_b_p0;
            4'b0110: alu_res_p0 = alu_a_p0 ^ alu_b_p0;
            4'b0111: alu_res_p0 = ~(alu_a_p0 | alu_b_p0);
            4'b1000,
            4'b1001: alu_res_p0 = alu_b_p0 << (WIDTH / 2);
            4'b1010: alu_res_p0 = {{(WIDTH-1){1'b0}}, ($unsigned(alu_a_p0) < $unsigned(alu_b_p0))};
            4'b1011: alu_res_p0 = {{(WIDTH-1){1'b0}}, (alu_a_p0 < alu_b_p0)};
            4'b1100: alu_res_p0 = alu_b_p0 >>> alu_a_p0[SHW-1:0];
            4'b1101: alu_res_p0 = $unsigned(alu_b_p0) >> alu_a_p0[SHW-1:0];
            default: alu_res_p0 = alu_b_p0 << alu_a_p0[SHW-1:0];
        endcase
    end

    assign needs_md  = ((in_md_op >= MD_MULT) && (in_md_op <= MD_MTLO)) ||
                       (in_hilo_rd == 2'd1) || (in_hilo_rd == 2'd2);
    assign out_stall = in_valid & ~in_flush & md_busy & needs_md;
    assign accept    = in_valid & ~out_stall & ~in_flush;
    assign md_start  = accept && (in_md_op >= MD_MULT) && (in_md_op <= MD_DIVU);
    assign mt_hi     = accept && (in_md_op == MD_MTHI);
    assign mt_lo     = accept && (in_md_op == MD_MTLO);
    assign out_md_busy = md_busy;

    // ---- stage p1: multiply/divide iteration ----
    logic             md_is_div, md_neg_q, md_neg_r, md_div0;
    logic [WIDTH-1:0] md_dividend, md_mcand, md_acc, md_lo;
    logic [WIDTH-1:0] acc_nxt, lo_nxt, res_hi, res_lo;
    logic [WIDTH:0]   mul_add, div_shift, div_trial;
    logic [2*WIDTH-1:0] prod;
    logic             op_signed;
    logic [WIDTH-1:0] mag_a, mag_b;

    assign op_signed = (in_md_op == MD_MULT) || (in_md_op == MD_DIV);
    assign mag_a     = cond_neg(in_rs_data, op_signed & in_rs_data[WIDTH-1]);
    assign mag_b     = cond_neg(in_rt_data, op_signed & in_rt_data[WIDTH-1]);

    // One shift-add or restoring-divide step, plus sign fix-up of the final result
    always_comb begin
        mul_add   = {1'b0, md_acc} + (md_lo[0] ? {1'b0, md_mcand} : '0);
        div_shift = {md_acc, md_lo[WIDTH-1]};
        div_trial = div_shift - {1'b0, md_mcand};
        acc_nxt   = '0;
        lo_nxt    = '0;
        if (md_is_div) begin
            if (!div_trial[WIDTH]) begin
                acc_nxt = div_trial[WIDTH-1:0];
                lo_nxt  = {md_lo[WIDTH-2:0], 1'b1};
            end else begin
                acc_nxt = div_shift[WIDTH-1:0];
                lo_nxt  = {md_lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_nxt = mul_add[WIDTH:1];
            lo_nxt  = {mul_add[0], md_lo[WIDTH-1:1]};
        end
        prod   = cond_neg2({acc_nxt, lo_nxt}, md_neg_q);
        res_hi = prod[2*WIDTH-1:WIDTH];
        res_lo = prod[WIDTH-1:0];
        if (md_is_div) begin
            if (md_div0) begin
                res_lo = '1;
                res_hi = md_dividend;
            end else begin
                res_lo = cond_neg(lo_nxt, md_neg_q);
                res_hi = cond_neg(acc_nxt, md_neg_r);
            end
        end
    end

    // Datapath registers of the unit: loaded on start, stepped while busy
    always_ff @(posedge in_clk) begin
        if (md_start) begin
            md_is_div   <= (in_md_op == MD_DIV) || (in_md_op == MD_DIVU);
            md_neg_q    <= op_signed & (in_rs_data[WIDTH-1] ^ in_rt_data[WIDTH-1]);
            md_neg_r    <= op_signed & in_rs_data[WIDTH-1];
            md_div0     <= (in_rt_data == '0);
            md_dividend <= in_rs_data;
            md_mcand    <= mag_b;
            md_acc      <= '0;
            md_lo       <= mag_a;
        end else if (md_busy) begin
            md_acc <= acc_nxt;
            md_lo  <= lo_nxt;
        end
    end

    // Busy/counter control and the architectural HI/LO registers
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            md_busy <= 1'b0;
            md_cnt  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else if (md_start) begin
            md_busy <= 1'b1;
            md_cnt  <= CW'(WIDTH);
        end else if (md_busy) begin
            md_cnt <= md_cnt - 1'b1;
            if (md_cnt == CW'(1)) begin
                md_busy <= 1'b0;
                hi_q    <= res_hi;
                lo_q    <= res_lo;
            end
        end else begin
            if (mt_hi) hi_q <= in_rs_data;
            if (mt_lo) lo_q <= in_rs_data;
        end
    end

    // ---- stage p1: EX/MEM register ----
    // Capture accepted instructions; otherwise insert a bubble that holds data
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            out_valid      <= 1'b0;
            out_dmem_ena   <= 1'b0;
            out_dmem_wena  <= 1'b0;
            out_dmem_type  <= '0;
            out_rs_data    <= '0;
            out_rt_data    <= '0;
            out_rd_waddr   <= '0;
            out_rd_sel     <= 1'b0;
            out_rd_wena    <= 1'b0;
            out_alu_result <= '0;
            out_overflow   <= 1'b0;
        end else begin
            out_valid <= accept;
            if (accept) begin
                out_dmem_ena  <= in_dmem_ena;
                out_dmem_wena <= in_dmem_wena;
                out_dmem_type <= in_dmem_type;
                out_rs_data   <= in_rs_data;
                out_rt_data   <= in_rt_data;
                out_rd_waddr  <= in_rd_waddr;
                out_rd_sel    <= in_rd_sel;
                out_rd_wena   <= in_rd_wena;
                out_overflow  <= alu_ovf_p0;
                case (in_hilo_rd)
                    2'd1:    out_alu_result <= hi_q;
                    2'd2:    out_alu_result <= lo_q;
                    default: out_alu_result <= alu_res_p0;
                endcase
            end else begin
                out_dmem_ena <= 1'b0;
                out_rd_wena  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pipe_ex_md.sv
// Directed bench for pipe_ex_md with a result scoreboard.
module tb_pipe_ex_md;

    localparam logic [3:0] ADDU = 4'b0000;
    localparam logic [3:0] ADD  = 4'b0010;
    localparam logic [3:0] SUB  = 4'b0011;
    localparam logic [3:0] SLT  = 4'b1011;
    localparam logic [3:0] SLL  = 4'b1111;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_flush, in_dmem_ena, in_dmem_wena;
    logic [1:0]  in_dmem_type;
    logic [31:0] in_rs_data, in_rt_data, in_immed, in_shamt;
    logic [4:0]  in_rd_waddr;
    logic        in_rd_sel, in_rd_wena, in_alu_a_sel, in_alu_b_sel;
    logic [3:0]  in_alu_sel;
    logic [2:0]  in_md_op;
    logic [1:0]  in_hilo_rd;
    logic        out_stall, out_valid, out_dmem_ena, out_dmem_wena;
    logic [1:0]  out_dmem_type;
    logic [31:0] out_rs_data, out_rt_data, out_alu_result;
    logic [4:0]  out_rd_waddr;
    logic        out_rd_sel, out_rd_wena, out_overflow, out_md_busy;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] sb[$];

    pipe_ex_md #(.WIDTH(32)) dut (
        .in_clk(clk), .in_rst_n(rst_n), .in_valid(in_valid), .in_flush(in_flush),
        .in_dmem_ena(in_dmem_ena), .in_dmem_wena(in_dmem_wena), .in_dmem_type(in_dmem_type),
        .in_rs_data(in_rs_data), .in_rt_data(in_rt_data), .in_immed(in_immed),
        .in_shamt(in_shamt), .in_rd_waddr(in_rd_waddr), .in_rd_sel(in_rd_sel),
        .in_rd_wena(in_rd_wena), .in_alu_a_sel(in_alu_a_sel), .in_alu_b_sel(in_alu_b_sel),
        .in_alu_sel(in_alu_sel), .in_md_op(in_md_op), .in_hilo_rd(in_hilo_rd),
        .out_stall(out_stall), .out_valid(out_valid), .out_dmem_ena(out_dmem_ena),
        .out_dmem_wena(out_dmem_wena), .out_dmem_type(out_dmem_type),
        .out_rs_data(out_rs_data), .out_rt_data(out_rt_data), .out_rd_waddr(out_rd_waddr),
        .out_rd_sel(out_rd_sel), .out_rd_wena(out_rd_wena), .out_alu_result(out_alu_result),
        .out_overflow(out_overflow), .out_md_busy(out_md_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        in_valid = 0; in_flush = 0; in_md_op = 0; in_hilo_rd = 0; in_alu_sel = ADDU;
        in_rs_data = 0; in_rt_data = 0; in_immed = 0; in_shamt = 0;
        in_alu_a_sel = 0; in_alu_b_sel = 0; in_rd_waddr = 0; in_rd_sel = 0;
        in_rd_wena = 0; in_dmem_ena = 0; in_dmem_wena = 0; in_dmem_type = 0;
    endtask

    task automatic drive(input logic [2:0] md, input logic [1:0] hr, input logic [3:0] alu,
                         input logic [31:0] rs, input logic [31:0] rt, input logic fl);
        idle();
        in_valid = 1; in_flush = fl; in_md_op = md; in_hilo_rd = hr; in_alu_sel = alu;
        in_rs_data = rs; in_rt_data = rt; in_rd_waddr = 5'd3; in_rd_wena = 1;
        in_dmem_ena = 1; in_dmem_type = 2'd2;
    endtask

    // Advance one edge and compare any produced result against the scoreboard
    task automatic tick();
        @(posedge clk); #1;
        if (out_valid) begin
            if (sb.size() == 0) chk("valid_no_expect", {31'b0, out_valid}, 32'd0);
            else chk("result", out_alu_result, sb.pop_front());
        end
    endtask

    task automatic wait_stall(output int n);
        n = 0;
        while (out_stall && n < 100) begin tick(); n++; end
    endtask

    task automatic wait_busy(output int n);
        n = 0;
        while (out_md_busy && n < 100) begin tick(); n++; end
    endtask

    task automatic md_run(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_lo, input logic [31:0] exp_hi);
        int n;
        drive(op, 2'd0, ADDU, a, b, 1'b0); sb.push_back(a + b); tick();
        chk({tag, "_busy"}, {31'b0, out_md_busy}, 32'd1);
        drive(3'd0, 2'd2, ADDU, 0, 0, 1'b0); sb.push_back(exp_lo); #1;
        chk({tag, "_stall"}, {31'b0, out_stall}, 32'd1);
        wait_stall(n);
        chk({tag, "_stall_cycles"}, n, 32'd32);
        tick();
        drive(3'd0, 2'd1, ADDU, 0, 0, 1'b0); sb.push_back(exp_hi); #1;
        chk({tag, "_mfhi_nostall"}, {31'b0, out_stall}, 32'd0);
        tick();
        idle();
    endtask

    initial begin
        int n;
        logic [31:0] held;
        idle();
        rst_n = 0;
        #12;
        chk("rst_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_result", out_alu_result, 32'd0);
        chk("rst_busy", {31'b0, out_md_busy}, 32'd0);
        chk("rst_stall", {31'b0, out_stall}, 32'd0);
        @(posedge clk); #1; rst_n = 1;

        // HI/LO read back zero after reset
        drive(3'd0, 2'd1, ADDU, 32'h55, 32'h1, 1'b0); sb.push_back(32'd0); tick();
        drive(3'd0, 2'd2, ADDU, 32'h55, 32'h1, 1'b0); sb.push_back(32'd0); tick();

        // Plain ALU: 5 + 7
        drive(3'd0, 2'd0, ADD, 32'd5, 32'd7, 1'b0); sb.push_back(32'd12); tick();
        chk("alu_valid", {31'b0, out_valid}, 32'd1);
        chk("alu_wena", {31'b0, out_rd_wena}, 32'd1);
        chk("alu_rs_pass", out_rs_data, 32'd5);

        // Back-to-back ADDUs, one per cycle, no stall
        for (int i = 0; i < 5; i++) begin
            drive(3'd0, 2'd0, ADDU, 32'(i * 3), 32'd100, 1'b0); sb.push_back(32'(i * 3 + 100)); #1;
            chk("b2b_nostall", {31'b0, out_stall}, 32'd0);
            tick();
        end

        // Signed overflow on SUB, SLT, immediate and shamt operands
        drive(3'd0, 2'd0, SUB, 32'h8000_0000, 32'd1, 1'b0); sb.push_back(32'h7FFF_FFFF); tick();
        chk("sub_ovf", {31'b0, out_overflow}, 32'd1);
        drive(3'd0, 2'd0, SLT, 32'hFFFF_FFFF, 32'd1, 1'b0); sb.push_back(32'd1); tick();
        chk("slt_noovf", {31'b0, out_overflow}, 32'd0);
        drive(3'd0, 2'd0, ADD, 32'd5, 32'd999, 1'b0); in_alu_b_sel = 1; in_immed = 32'd100;
        sb.push_back(32'd105); tick();
        drive(3'd0, 2'd0, SLL, 32'd77, 32'd3, 1'b0); in_alu_a_sel = 1; in_shamt = 32'd4;
        sb.push_back(32'h30); tick();

        // Bubble: data held, write enables cleared
        held = out_alu_result;
        idle(); tick();
        chk("bubble_valid", {31'b0, out_valid}, 32'd0);
        chk("bubble_wena", {31'b0, out_rd_wena}, 32'd0);
        chk("bubble_dmem", {31'b0, out_dmem_ena}, 32'd0);
        chk("bubble_hold", out_alu_result, held);

        // Multiply/divide with dependent MFLO/MFHI
        md_run("mult",  3'd1, 32'hFFFF_FFFD, 32'd4,         32'hFFFF_FFF4, 32'hFFFF_FFFF);
        md_run("div",   3'd3, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32'hFFFF_FFFF);
        md_run("div_nd",3'd3, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1);
        md_run("divu0", 3'd4, 32'd9,         32'd0,         32'hFFFF_FFFF, 32'd9);
        md_run("divmin",3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
        md_run("multu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE);

        // Non-blocking: MULTU 3*5 then ten independent ADDs
        drive(3'd2, 2'd0, ADDU, 32'd3, 32'd5, 1'b0); sb.push_back(32'd8); tick();
        for (int i = 0; i < 10; i++) begin
            drive(3'd0, 2'd0, ADD, 32'(i), 32'd1000, 1'b0); sb.push_back(32'(i + 1000)); #1;
            chk("nb_nostall", {31'b0, out_stall}, 32'd0);
            tick();
        end
        chk("nb_still_busy", {31'b0, out_md_busy}, 32'd1);
        idle(); wait_busy(n);
        chk("nb_busy_cycles", n, 32'd22);
        drive(3'd0, 2'd2, ADDU, 0, 0, 1'b0); sb.push_back(32'd15); #1;
        chk("nb_mflo_nostall", {31'b0, out_stall}, 32'd0);
        tick();

        // MTHI/MTLO, and a flushed MTHI that must not write HI
        drive(3'd5, 2'd0, ADDU, 32'h1234, 32'd0, 1'b0); sb.push_back(32'h1234); tick();
        drive(3'd6, 2'd0, ADDU, 32'h5678, 32'd0, 1'b0); sb.push_back(32'h5678); tick();
        drive(3'd5, 2'd0, ADDU, 32'hAA, 32'd0, 1'b1); #1;
        chk("flush_nostall", {31'b0, out_stall}, 32'd0);
        tick();
        chk("flush_valid", {31'b0, out_valid}, 32'd0);
        drive(3'd0, 2'd1, ADDU, 0, 0, 1'b0); sb.push_back(32'h1234); tick();
        drive(3'd0, 2'd2, ADDU, 0, 0, 1'b0); sb.push_back(32'h5678); tick();

        // Flush during a stalled MFLO
        drive(3'd1, 2'd0, ADDU, 32'd6, 32'd7, 1'b0); sb.push_back(32'd13); tick();
        drive(3'd0, 2'd2, ADDU, 0, 0, 1'b0); #1;
        chk("fs_stall", {31'b0, out_stall}, 32'd1);
        tick(); tick();
        chk("fs_stalled_novalid", {31'b0, out_valid}, 32'd0);
        in_flush = 1; #1;
        chk("fs_stall_drop", {31'b0, out_stall}, 32'd0);
        tick();
        chk("fs_bubble", {31'b0, out_valid}, 32'd0);
        chk("fs_busy_on", {31'b0, out_md_busy}, 32'd1);
        idle(); wait_busy(n);
        chk("fs_busy_ends", {31'b0, out_md_busy}, 32'd0);
        drive(3'd0, 2'd2, ADDU, 0, 0, 1'b0); sb.push_back(32'd42); tick();

        // Asynchronous reset in the middle of a multiply
        drive(3'd1, 2'd0, ADDU, 32'd2, 32'd3, 1'b0); sb.push_back(32'd5); tick();
        idle(); tick(); tick();
        #3 rst_n = 0; #1;
        chk("arst_result", out_alu_result, 32'd0);
        chk("arst_busy", {31'b0, out_md_busy}, 32'd0);
        chk("arst_wena", {31'b0, out_rd_wena}, 32'd0);
        @(posedge clk); #2; rst_n = 1;
        drive(3'd0, 2'd2, ADDU, 0, 0, 1'b0); sb.push_back(32'd0); tick();
        drive(3'd0, 2'd1, ADDU, 0, 0, 1'b0); sb.push_back(32'd0); tick();
        idle(); tick();

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
